// File: rtl/pc_fetch_master.sv
// Instruction-fetch master for the 32-word program memory.
// Keeps the PC, issues one-cycle-latency reads, buffers returned words in a
// small FIFO and hands them to decode on a valid/ready handshake.
module pc_fetch_master #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int RESET_PC   = 0
) (
    input  logic                              clk_clk,
    input  logic                              reset_reset_n,
    input  logic                              fetch_en,
    input  logic                              redirect_valid,
    input  logic [ADDR_W-1:0]                 redirect_pc,
    output logic [ADDR_W-1:0]                 mem_address,
    output logic                              mem_chipselect,
    output logic                              mem_clken,
    output logic                              mem_write,
    output logic [DATA_W/8-1:0]               mem_byteenable,
    output logic                              mem_debugaccess,
    input  logic [DATA_W-1:0]                 mem_readdata,
    output logic                              instr_valid,
    input  logic                              instr_ready,
    output logic [DATA_W-1:0]                 instr_data,
    output logic [ADDR_W-1:0]                 instr_pc,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD,
        ST_FLUSH
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic                 inflight_q, inflight_d;
    logic [ADDR_W-1:0]    inflight_addr_q, inflight_addr_d;
    logic                 clken_q, clken_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [DATA_W-1:0]    fifo_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0]    fifo_data_d [FIFO_DEPTH];
    logic [ADDR_W-1:0]    fifo_pc_q   [FIFO_DEPTH];
    logic [ADDR_W-1:0]    fifo_pc_d   [FIFO_DEPTH];

    logic [LVL_W:0]       credits;
    logic                 has_credit;
    logic                 issue;
    logic                 push;
    logic                 pop;

    // Free slots once every buffered word and the outstanding read are counted
    always_comb begin
        credits    = (LVL_W+1)'(FIFO_DEPTH) - {1'b0, level_q} - {{LVL_W{1'b0}}, inflight_q};
        has_credit = (credits != '0);
    end

    // Fetch state register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect overrides every other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (fetch_en) state_d = ST_RUN;
            ST_RUN: begin
                if (!fetch_en)        state_d = ST_IDLE;
                else if (!has_credit) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!fetch_en)        state_d = ST_IDLE;
                else if (has_credit)  state_d = ST_RUN;
            end
            ST_FLUSH: state_d = fetch_en ? ST_RUN : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (redirect_valid) state_d = ST_FLUSH;
    end

    // Read issue and handshake strobes; FLUSH already has an empty buffer, so
    // the redirect target is fetched in the very next cycle
    always_comb begin
        issue = !redirect_valid && has_credit &&
                ((state_q == ST_RUN) || ((state_q == ST_FLUSH) && fetch_en));
        instr_valid    = (level_q != '0);
        push           = inflight_q && !redirect_valid;
        pop            = instr_valid && instr_ready && !redirect_valid;
        mem_chipselect = issue;
        mem_address    = pc_q;
        mem_clken      = clken_q;
        mem_write      = 1'b0;
        mem_byteenable = '1;
        mem_debugaccess = 1'b0;
        fifo_level     = level_q;
        instr_data     = instr_valid ? fifo_data_q[rd_ptr_q] : '0;
        instr_pc       = instr_valid ? fifo_pc_q[rd_ptr_q]   : '0;
    end

    // PC, outstanding-read tracking and instruction buffer next values
    always_comb begin
        pc_d            = pc_q;
        inflight_d      = issue;
        inflight_addr_d = issue ? pc_q : inflight_addr_q;
        clken_d         = 1'b1;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        level_d         = level_q;
        fifo_data_d     = fifo_data_q;
        fifo_pc_d       = fifo_pc_q;

        if (redirect_valid) begin
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (issue) pc_d = pc_q + 1'b1;
            if (push) begin
                fifo_data_d[wr_ptr_q] = mem_readdata;
                fifo_pc_d[wr_ptr_q]   = inflight_addr_q;
                wr_ptr_d              = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Datapath registers; reset drops any read that is still outstanding
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pc_q            <= ADDR_W'(RESET_PC);
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            clken_q         <= 1'b0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            level_q         <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            pc_q            <= pc_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            clken_q         <= clken_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            level_q         <= level_d;
            fifo_data_q     <= fifo_data_d;
            fifo_pc_q       <= fifo_pc_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_master.sv
// Self-checking bench for pc_fetch_master: a per-cycle vector table plus
// hand-written sequences for back-pressure, redirect and reset corner cases.
module tb_pc_fetch_master;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [4:0]  redirect_pc;
    logic [4:0]  mem_address;
    logic        mem_chipselect;
    logic        mem_clken;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic        mem_debugaccess;
    logic [31:0] mem_readdata = 32'hDEAD_BEEF;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [4:0]  instr_pc;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        fe;
        logic        rv;
        logic [4:0]  rpc;
        logic        rdy;
        logic        exp_cs;
        logic [4:0]  exp_addr;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [4:0]  exp_pc;
        logic [2:0]  exp_level;
    } vec_t;

    vec_t vecs[$];

    pc_fetch_master #(
        .ADDR_W(5), .DATA_W(32), .FIFO_DEPTH(4), .RESET_PC(0)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_debugaccess(mem_debugaccess),
        .mem_readdata   (mem_readdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .fifo_level     (fifo_level)
    );

    always #5 clk_clk = ~clk_clk;

    // Program memory: word i holds 0xA000_0000 + i, one cycle read latency
    always @(posedge clk_clk) begin
        if (mem_chipselect) mem_readdata <= 32'hA000_0000 + {27'b0, mem_address};
        else                mem_readdata <= 32'hDEAD_BEEF;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic fe, input logic rv, input logic [4:0] rpc, input logic rdy);
        @(posedge clk_clk);
        #1;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        @(negedge clk_clk);
    endtask

    task automatic doReset();
        reset_reset_n  = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        repeat (3) @(posedge clk_clk);
        #3 reset_reset_n = 1'b1;
    endtask

    function automatic vec_t mkVec(logic fe, logic rv, logic [4:0] rpc, logic rdy, logic cs, logic [4:0] addr,
                                   logic v, logic [31:0] d, logic [4:0] p, logic [2:0] lvl);
        vec_t t;
        t.fe = fe; t.rv = rv; t.rpc = rpc; t.rdy = rdy;
        t.exp_cs = cs; t.exp_addr = addr; t.exp_valid = v;
        t.exp_data = d; t.exp_pc = p; t.exp_level = lvl;
        return t;
    endfunction

    initial begin
        int  cs_count;
        int  drained;
        int  first_addr;
        bit  found;

        // Streaming from reset, redirect to 30 with wrap, then fetch_en drop
        vecs.push_back(mkVec(1,0, 0,1, 0, 0, 0,32'h0,         0, 0));
        vecs.push_back(mkVec(1,0, 0,1, 1, 0, 0,32'h0,         0, 0));
        vecs.push_back(mkVec(1,0, 0,1, 1, 1, 0,32'h0,         0, 0));
        vecs.push_back(mkVec(1,0, 0,1, 1, 2, 1,32'hA000_0000, 0, 1));
        vecs.push_back(mkVec(1,0, 0,1, 1, 3, 1,32'hA000_0001, 1, 1));
        vecs.push_back(mkVec(1,0, 0,1, 1, 4, 1,32'hA000_0002, 2, 1));
        vecs.push_back(mkVec(1,1,30,1, 0, 0, 1,32'hA000_0003, 3, 1));
        vecs.push_back(mkVec(1,0, 0,1, 1,30, 0,32'h0,         0, 0));
        vecs.push_back(mkVec(1,0, 0,1, 1,31, 0,32'h0,         0, 0));
        vecs.push_back(mkVec(1,0, 0,1, 1, 0, 1,32'hA000_001E,30, 1));
        vecs.push_back(mkVec(1,0, 0,1, 1, 1, 1,32'hA000_001F,31, 1));
        vecs.push_back(mkVec(1,0, 0,1, 1, 2, 1,32'hA000_0000, 0, 1));
        vecs.push_back(mkVec(0,0, 0,1, 1, 3, 1,32'hA000_0001, 1, 1));
        vecs.push_back(mkVec(0,0, 0,1, 0, 0, 1,32'hA000_0002, 2, 1));
        vecs.push_back(mkVec(0,0, 0,1, 0, 0, 1,32'hA000_0003, 3, 1));
        vecs.push_back(mkVec(0,0, 0,1, 0, 0, 0,32'h0,         0, 0));

        // Reset values and constant master outputs
        reset_reset_n = 1'b0;
        doReset();
        reset_reset_n = 1'b0;
        #1;
        checkOutput("rst_cs",     {31'b0, mem_chipselect}, 0);
        checkOutput("rst_clken",  {31'b0, mem_clken}, 0);
        checkOutput("rst_addr",   {27'b0, mem_address}, 0);
        checkOutput("rst_valid",  {31'b0, instr_valid}, 0);
        checkOutput("rst_data",   instr_data, 0);
        checkOutput("rst_pc",     {27'b0, instr_pc}, 0);
        checkOutput("rst_level",  {29'b0, fifo_level}, 0);
        checkOutput("const_write", {31'b0, mem_write}, 0);
        checkOutput("const_be",    {28'b0, mem_byteenable}, 32'hF);
        checkOutput("const_dbg",   {31'b0, mem_debugaccess}, 0);

        doReset();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].fe, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            checkOutput($sformatf("v%0d_cs", i), {31'b0, mem_chipselect}, {31'b0, vecs[i].exp_cs});
            checkOutput($sformatf("v%0d_clken", i), {31'b0, mem_clken}, 1);
            if (vecs[i].exp_cs)
                checkOutput($sformatf("v%0d_addr", i), {27'b0, mem_address}, {27'b0, vecs[i].exp_addr});
            checkOutput($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("v%0d_data", i), instr_data, vecs[i].exp_data);
                checkOutput($sformatf("v%0d_ipc", i), {27'b0, instr_pc}, {27'b0, vecs[i].exp_pc});
            end
            checkOutput($sformatf("v%0d_level", i), {29'b0, fifo_level}, {29'b0, vecs[i].exp_level});
        end

        // Back-pressure: four reads fill the buffer, then draining resumes at 4
        doReset();
        cs_count = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 0, 0, 0);
            if (mem_chipselect) cs_count++;
        end
        checkOutput("bp_cs_count", cs_count, 4);
        checkOutput("bp_level",    {29'b0, fifo_level}, 4);
        checkOutput("bp_valid",    {31'b0, instr_valid}, 1);
        checkOutput("bp_head",     instr_data, 32'hA000_0000);
        drained    = 0;
        first_addr = -1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, 0, 1);
            if (instr_valid && drained < 4) begin
                checkOutput($sformatf("bp_drain%0d_data", drained), instr_data, 32'hA000_0000 + drained);
                checkOutput($sformatf("bp_drain%0d_pc", drained), {27'b0, instr_pc}, drained);
                drained++;
            end
            if (mem_chipselect && first_addr < 0) first_addr = int'(mem_address);
        end
        checkOutput("bp_drained",    drained, 4);
        checkOutput("bp_resume_addr", first_addr, 4);

        // Redirect to 17 while the read of address 5 is in flight
        doReset();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(1, 0, 0, 1);
            if (mem_chipselect && mem_address == 5'd5) found = 1;
        end
        checkOutput("rd_found5", {31'b0, found}, 1);
        applyStimulus(1, 1, 17, 1);
        checkOutput("rd_T_cs", {31'b0, mem_chipselect}, 0);
        applyStimulus(1, 0, 0, 1);
        checkOutput("rd_T1_valid", {31'b0, instr_valid}, 0);
        checkOutput("rd_T1_cs",    {31'b0, mem_chipselect}, 1);
        checkOutput("rd_T1_addr",  {27'b0, mem_address}, 17);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1, 0, 0, 1);
            if (instr_valid) begin
                found = 1;
                checkOutput("rd_first_pc",   {27'b0, instr_pc}, 17);
                checkOutput("rd_first_data", instr_data, 32'hA000_0011);
            end
        end
        checkOutput("rd_delivered", {31'b0, found}, 1);

        // Redirect coinciding with a pop on a full buffer
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0);
        checkOutput("rp_full", {29'b0, fifo_level}, 4);
        applyStimulus(1, 1, 9, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("rp_level", {29'b0, fifo_level}, 0);
        checkOutput("rp_valid", {31'b0, instr_valid}, 0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1, 0, 0, 1);
            if (instr_valid) begin
                found = 1;
                checkOutput("rp_first_pc",   {27'b0, instr_pc}, 9);
                checkOutput("rp_first_data", instr_data, 32'hA000_0009);
            end
        end
        checkOutput("rp_delivered", {31'b0, found}, 1);

        // Asynchronous reset in the middle of a stream
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 1);
        @(posedge clk_clk);
        #2 reset_reset_n = 1'b0;
        #1;
        checkOutput("ar_cs",    {31'b0, mem_chipselect}, 0);
        checkOutput("ar_clken", {31'b0, mem_clken}, 0);
        checkOutput("ar_addr",  {27'b0, mem_address}, 0);
        checkOutput("ar_valid", {31'b0, instr_valid}, 0);
        checkOutput("ar_data",  instr_data, 0);
        checkOutput("ar_pc",    {27'b0, instr_pc}, 0);
        checkOutput("ar_level", {29'b0, fifo_level}, 0);
        repeat (2) @(posedge clk_clk);
        #3 reset_reset_n = 1'b1;
        first_addr = -1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1, 0, 0, 1);
            if (mem_chipselect && first_addr < 0) first_addr = int'(mem_address);
            if (instr_valid) begin
                found = 1;
                checkOutput("ar_first_pc",   {27'b0, instr_pc}, 0);
                checkOutput("ar_first_data", instr_data, 32'hA000_0000);
            end
        end
        checkOutput("ar_first_addr", first_addr, 0);
        checkOutput("ar_delivered",  {31'b0, found}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
